// File: rtl/rx_deinterleaver.sv
// Receive-side 802.11a deinterleaver: collects one OFDM symbol of coded bits
// into a ping-pong bank at permuted addresses and streams it out in coded order.
module rx_deinterleaver (
    input  logic       clk,
    input  logic       rst,
    input  logic       in,
    input  logic       run,
    input  logic [1:0] mod,
    output logic       ready,
    output logic       out,
    output logic       valid
);

    function automatic logic [8:0] sym_len(input logic [1:0] m);
        case (m)
            2'b00:   sym_len = 9'd48;
            2'b01:   sym_len = 9'd96;
            2'b10:   sym_len = 9'd192;
            default: sym_len = 9'd288;
        endcase
    endfunction

    // Both permutation steps with constant divisors: 16*x/N reduces to x/(N/16).
    function automatic logic [8:0] wr_addr(input logic [8:0] j, input logic [1:0] m);
        logic [12:0] jj;
        logic [12:0] t;
        logic [12:0] i;
        logic [12:0] k;
        jj = {4'd0, j};
        t  = 13'd0;
        case (m)
            2'b00: begin
                i = jj;
                k = (13'd16 * i) - (13'd47 * (i / 13'd3));
            end
            2'b01: begin
                i = jj;
                k = (13'd16 * i) - (13'd95 * (i / 13'd6));
            end
            2'b10: begin
                t = jj + (jj / 13'd12);
                i = (jj & ~13'd1) + (t & 13'd1);
                k = (13'd16 * i) - (13'd191 * (i / 13'd12));
            end
            default: begin
                t = jj + (jj / 13'd18);
                i = (13'd3 * (jj / 13'd3)) + (t % 13'd3);
                k = (13'd16 * i) - (13'd287 * (i / 13'd18));
            end
        endcase
        wr_addr = 9'(k);
    endfunction

    logic [287:0] bank_q [2];
    logic [1:0]   bank_mod_q [2];
    logic [1:0]   bank_mod_d [2];
    logic [1:0]   full_q, full_d;
    logic         wr_sel_q, wr_sel_d;
    logic [8:0]   wr_j_q, wr_j_d;
    logic [8:0]   rd_k_q, rd_k_d;
    logic         out_q, out_d;
    logic         valid_q, valid_d;

    logic         rd_sel;
    logic [1:0]   wr_mod;
    logic [8:0]   wr_n;
    logic [8:0]   rd_n;
    logic [8:0]   wr_a;
    logic         accept;
    logic         wr_last;
    logic         rd_busy;
    logic         rd_last;
    logic         swap;

    // The first bit of a symbol uses the live mod; later bits use the latched copy.
    assign rd_sel  = ~wr_sel_q;
    assign wr_mod  = (wr_j_q == 9'd0) ? mod : bank_mod_q[wr_sel_q];
    assign wr_n    = sym_len(wr_mod);
    assign rd_n    = sym_len(bank_mod_q[rd_sel]);
    assign wr_a    = wr_addr(wr_j_q, wr_mod);
    assign ready   = ~full_q[wr_sel_q];
    assign accept  = run & ready;
    assign wr_last = accept & (wr_j_q == wr_n - 9'd1);
    assign rd_busy = full_q[rd_sel];
    assign rd_last = rd_busy & (rd_k_q == rd_n - 9'd1);
    assign swap    = (full_q[wr_sel_q] | wr_last) & (~rd_busy | rd_last);

    always_comb begin
        full_d     = full_q;
        wr_sel_d   = wr_sel_q;
        wr_j_d     = wr_j_q;
        bank_mod_d = bank_mod_q;
        rd_k_d     = rd_k_q;
        out_d      = 1'b0;
        valid_d    = 1'b0;

        if (wr_last) full_d[wr_sel_q] = 1'b1;
        if (rd_last) full_d[rd_sel] = 1'b0;
        if (swap)    wr_sel_d = ~wr_sel_q;

        if (accept) begin
            wr_j_d = wr_last ? 9'd0 : wr_j_q + 9'd1;
            if (wr_j_q == 9'd0) bank_mod_d[wr_sel_q] = mod;
        end

        // rd_k_q is the index currently presented on out while the read bank is full.
        if (swap) begin
            out_d   = bank_q[wr_sel_q][0];
            valid_d = 1'b1;
            rd_k_d  = 9'd0;
        end else if (rd_busy && !rd_last) begin
            rd_k_d  = rd_k_q + 9'd1;
            out_d   = bank_q[rd_sel][rd_k_q + 9'd1];
            valid_d = 1'b1;
        end else begin
            rd_k_d  = 9'd0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            full_q        <= 2'b00;
            wr_sel_q      <= 1'b0;
            wr_j_q        <= 9'd0;
            bank_mod_q[0] <= 2'b00;
            bank_mod_q[1] <= 2'b00;
            rd_k_q        <= 9'd0;
            out_q         <= 1'b0;
            valid_q       <= 1'b0;
        end else begin
            full_q     <= full_d;
            wr_sel_q   <= wr_sel_d;
            wr_j_q     <= wr_j_d;
            bank_mod_q <= bank_mod_d;
            rd_k_q     <= rd_k_d;
            out_q      <= out_d;
            valid_q    <= valid_d;
        end
    end

    // Bit storage carries no reset: every position is rewritten before it is read.
    always_ff @(posedge clk) begin
        if (accept) bank_q[wr_sel_q][wr_a] <= in;
    end

    assign out   = out_q;
    assign valid = valid_q;

endmodule

// File: tb/tb_rx_deinterleaver.sv
// Directed bench for rx_deinterleaver: a forward 802.11a interleaver model builds
// the received streams, and a queue holds the coded-order bits expected back.
module tb_rx_deinterleaver;

    logic       clk = 1'b0;
    logic       rst;
    logic       in;
    logic       run;
    logic [1:0] mod;
    logic       ready;
    logic       out;
    logic       valid;

    int tests_run = 0;
    int fail_cnt  = 0;
    int stall_cnt = 0;
    int cur_run   = 0;
    int last_run  = 0;
    int out_idx   = 0;
    bit mon_en    = 1'b0;

    logic [0:0]   exp_q[$];
    logic [287:0] rx_vec;
    logic [287:0] exp_vec;

    always #5 clk = ~clk;

    rx_deinterleaver dut (
        .clk   (clk),
        .rst   (rst),
        .in    (in),
        .run   (run),
        .mod   (mod),
        .ready (ready),
        .out   (out),
        .valid (valid)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            fail_cnt++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int sym_n(input logic [1:0] m);
        case (m)
            2'b00:   return 48;
            2'b01:   return 96;
            2'b10:   return 192;
            default: return 288;
        endcase
    endfunction

    function automatic int sym_s(input logic [1:0] m);
        case (m)
            2'b10:   return 2;
            2'b11:   return 3;
            default: return 1;
        endcase
    endfunction

    // Transmit-side interleaver: coded bit k goes out on the air at position j.
    function automatic int tx_pos(input int k, input int n, input int s);
        int i;
        i = (n / 16) * (k % 16) + k / 16;
        return s * (i / s) + (i + n - (16 * i) / n) % s;
    endfunction

    task automatic build_random(input logic [1:0] m);
        int n;
        int s;
        n = sym_n(m);
        s = sym_s(m);
        rx_vec  = '0;
        exp_vec = '0;
        for (int k = 0; k < n; k++) begin
            exp_vec[k] = 1'($urandom_range(0, 1));
            rx_vec[tx_pos(k, n, s)] = exp_vec[k];
        end
    endtask

    task automatic build_onehot(input int j_in, input int k_out);
        rx_vec  = '0;
        exp_vec = '0;
        rx_vec[j_in]   = 1'b1;
        exp_vec[k_out] = 1'b1;
    endtask

    // Presents nbits of rx_vec, holding each bit until ready; returns with the
    // last bit on the pins so a following call continues without a gap.
    task automatic drive_sym(input logic [1:0] m, input int nbits, input bit push, input bit toggle);
        int waits;
        if (push) begin
            for (int k = 0; k < sym_n(m); k++) exp_q.push_back(exp_vec[k]);
        end
        for (int j = 0; j < nbits; j++) begin
            waits = 0;
            @(negedge clk);
            in  = rx_vec[j];
            run = 1'b1;
            mod = (toggle && j > 0) ? ~m : m;
            while (ready !== 1'b1 && waits < 2000) begin
                stall_cnt++;
                waits++;
                @(negedge clk);
            end
            if (waits >= 2000) begin
                tests_run++;
                fail_cnt++;
                $error("FAIL ready_timeout: observed ready=%0b at bit %0d expected 1", ready, j);
            end
        end
    endtask

    task automatic idle_run();
        @(negedge clk);
        run = 1'b0;
        in  = 1'b0;
    endtask

    task automatic wait_drain();
        int cyc;
        cyc = 0;
        do begin
            @(negedge clk);
            #1;
            cyc++;
        end while ((exp_q.size() != 0 || valid === 1'b1) && cyc < 3000);
        if (cyc >= 3000) begin
            tests_run++;
            fail_cnt++;
            $error("FAIL drain_timeout: observed %0d bits pending expected 0", exp_q.size());
        end
    endtask

    // Output monitor: every valid bit is compared against the head of the queue.
    always @(negedge clk) begin
        logic [0:0] e;
        if (mon_en) begin
            if (valid === 1'b1) begin
                cur_run++;
                if (exp_q.size() == 0) begin
                    tests_run++;
                    fail_cnt++;
                    $error("FAIL unexpected_valid: observed valid=1 with out=%0b expected no output", out);
                end else begin
                    e = exp_q.pop_front();
                    check($sformatf("out_bit[%0d]", out_idx), 32'(out), 32'(e));
                end
                out_idx++;
            end else begin
                if (cur_run > 0) last_run = cur_run;
                cur_run = 0;
                check("idle_out", 32'(out), 32'd0);
            end
        end
    end

    initial begin
        rst = 1'b0;
        in  = 1'b0;
        run = 1'b0;
        mod = 2'b00;
        repeat (2) @(negedge clk);
        #1;
        check("reset_valid", 32'(valid), 32'd0);
        check("reset_out", 32'(out), 32'd0);
        check("reset_ready", 32'(ready), 32'd1);
        rst    = 1'b1;
        mon_en = 1'b1;

        // BPSK: j=1 -> index 16, with first-output latency
        build_onehot(1, 16);
        drive_sym(2'b00, 48, 1'b1, 1'b0);
        check("bpsk_no_early_valid", 32'(valid), 32'd0);
        idle_run();
        #1;
        check("bpsk_latency_valid", 32'(valid), 32'd1);
        wait_drain();
        check("bpsk_run_len", 32'(last_run), 32'd48);

        // QPSK: j=6 -> index 1, then j=1 -> index 16
        build_onehot(6, 1);
        drive_sym(2'b01, 96, 1'b1, 1'b0);
        idle_run();
        wait_drain();
        build_onehot(1, 16);
        drive_sym(2'b01, 96, 1'b1, 1'b0);
        idle_run();
        wait_drain();
        check("qpsk_run_len", 32'(last_run), 32'd96);

        // 16-QAM: j=12 -> index 17, then a random payload
        build_onehot(12, 17);
        drive_sym(2'b10, 192, 1'b1, 1'b0);
        idle_run();
        wait_drain();
        build_random(2'b10);
        drive_sym(2'b10, 192, 1'b1, 1'b0);
        idle_run();
        wait_drain();
        check("qam16_run_len", 32'(last_run), 32'd192);

        // 64-QAM: j=18 -> index 17, then three back-to-back random symbols
        build_onehot(18, 17);
        drive_sym(2'b11, 288, 1'b1, 1'b0);
        idle_run();
        wait_drain();
        stall_cnt = 0;
        for (int n = 0; n < 3; n++) begin
            build_random(2'b11);
            drive_sym(2'b11, 288, 1'b1, 1'b0);
        end
        idle_run();
        wait_drain();
        check("qam64_b2b_stalls", 32'(stall_cnt), 32'd0);
        check("qam64_b2b_run_len", 32'(last_run), 32'd864);

        // Mixed rates: 64-QAM then BPSK (mod toggled mid-symbol), then a third
        // symbol that must wait until the 64-QAM read finishes.
        stall_cnt = 0;
        build_random(2'b11);
        drive_sym(2'b11, 288, 1'b1, 1'b0);
        build_random(2'b00);
        drive_sym(2'b00, 48, 1'b1, 1'b1);
        build_random(2'b00);
        drive_sym(2'b00, 48, 1'b1, 1'b0);
        idle_run();
        wait_drain();
        check("mixed_stall_cycles", 32'(stall_cnt), 32'd240);
        check("mixed_run_len", 32'(last_run), 32'd384);

        // Reset while a symbol is reading out and a second one is half written
        build_random(2'b10);
        drive_sym(2'b10, 192, 1'b1, 1'b0);
        build_random(2'b10);
        drive_sym(2'b10, 100, 1'b0, 1'b0);
        idle_run();
        #2;
        rst = 1'b0;
        #1;
        check("midrst_valid", 32'(valid), 32'd0);
        check("midrst_out", 32'(out), 32'd0);
        check("midrst_ready", 32'(ready), 32'd1);
        exp_q.delete();
        repeat (3) @(negedge clk);
        #1;
        rst = 1'b1;
        build_random(2'b00);
        drive_sym(2'b00, 48, 1'b1, 1'b0);
        idle_run();
        wait_drain();
        check("post_reset_run_len", 32'(last_run), 32'd48);
        check("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, fail_cnt);
        $finish;
    end

endmodule
